// File: rtl/pll_sup_pkg.sv
// Shared state encodings and widths for the PLL lock supervisor.
// Pure declarations; no latency or backpressure of its own.
package pll_sup_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_RESET_PLL = 3'd0;
    localparam state_t ST_WAIT_LOCK = 3'd1;
    localparam state_t ST_STABLE    = 3'd2;
    localparam state_t ST_RELEASE   = 3'd3;
    localparam state_t ST_RUN       = 3'd4;
    localparam state_t ST_FAULT     = 3'd5;

    localparam int RELOCK_W = 8;

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between a PLL wrapper and its lock supervisor.
// Wires only; master drives lock status and requests, slave (supervisor) drives resets and status.
interface pll_lock_supervisor_if
    import pll_sup_pkg::*;
#(
    parameter int NUM_CLOCKS = 2
);
    logic                  pll_locked;
    logic                  force_relock;
    logic                  clear_fault;
    logic                  pll_rst;
    logic [NUM_CLOCKS-1:0] ch_rst_n;
    logic                  ready;
    logic                  fault;
    logic [RELOCK_W-1:0]   relock_count;

    modport master (
        output pll_locked, force_relock, clear_fault,
        input  pll_rst, ch_rst_n, ready, fault, relock_count
    );

    modport slave (
        input  pll_locked, force_relock, clear_fault,
        output pll_rst, ch_rst_n, ready, fault, relock_count
    );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser, resets to 0.
// Latency: 2 clk edges; no backpressure.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer, lock qualifier and staggered per-domain reset release with bounded relock retries.
// Latency: lock loss to channel reset 3 refclk edges; no backpressure, pulse inputs act only in RUN/FAULT.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_CLOCKS          = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int STAGGER_CYCLES      = 8,
    parameter int CNT_W               = 17
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    pll_lock_supervisor_if.slave  bus
);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    if (PLL_RST_CYCLES >= (1 << CNT_W) || LOCK_STABLE_CYCLES >= (1 << CNT_W) ||
        LOCK_TIMEOUT_CYCLES >= (1 << CNT_W) ||
        STAGGER_CYCLES * NUM_CLOCKS >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("pll_lock_supervisor: CNT_W too narrow for the cycle parameters");
    end
    if (MAX_RETRIES == 0) begin : g_bad_retries
        $error("pll_lock_supervisor: MAX_RETRIES must be at least 1");
    end

    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(STAGGER_CYCLES * NUM_CLOCKS);
    localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic                  locked_s;
    state_t                state;
    logic [CNT_W-1:0]      timer;
    logic [RETRY_W-1:0]    retries;
    logic                  pll_rst_q;
    logic [NUM_CLOCKS-1:0] ch_q;
    logic                  ready_q;
    logic                  fault_q;
    logic [RELOCK_W-1:0]   relock_q;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (locked_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET_PLL;
            timer     <= '0;
            retries   <= '0;
            pll_rst_q <= 1'b1;
            ch_q      <= '0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
            relock_q  <= '0;
        end else begin
            case (state)
                ST_RESET_PLL: begin
                    pll_rst_q <= 1'b1;
                    if (timer == RST_LAST) begin
                        state     <= ST_WAIT_LOCK;
                        timer     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= ST_STABLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer     <= '0;
                        retries   <= retries + RETRY_ONE;
                        pll_rst_q <= 1'b1;
                        if (retries + RETRY_ONE == RETRY_MAX) begin
                            state   <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state <= ST_RESET_PLL;
                        end
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    // A glitch only restarts qualification; it is not a failed attempt.
                    if (!locked_s) begin
                        state <= ST_WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        state <= ST_RELEASE;
                        timer <= '0;
                    end else begin
                        timer <= timer + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (!locked_s) begin
                        ch_q      <= '0;
                        state     <= ST_RESET_PLL;
                        timer     <= '0;
                        pll_rst_q <= 1'b1;
                    end else if (timer == RELEASE_LAST) begin
                        state   <= ST_RUN;
                        timer   <= '0;
                        ready_q <= 1'b1;
                        retries <= '0;
                    end else begin
                        timer <= timer + CNT_ONE;
                        for (int i = 0; i < NUM_CLOCKS; i++) begin
                            if (timer == CNT_W'(STAGGER_CYCLES * (i + 1) - 1)) begin
                                ch_q[i] <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (!locked_s || bus.force_relock) begin
                        ch_q      <= '0;
                        ready_q   <= 1'b0;
                        state     <= ST_RESET_PLL;
                        timer     <= '0;
                        pll_rst_q <= 1'b1;
                        // Only genuine lock loss is a relock event; a forced relock is not.
                        if (!locked_s && relock_q != '1) begin
                            relock_q <= relock_q + RELOCK_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    pll_rst_q <= 1'b1;
                    ch_q      <= '0;
                    ready_q   <= 1'b0;
                    if (bus.clear_fault) begin
                        fault_q <= 1'b0;
                        retries <= '0;
                        state   <= ST_RESET_PLL;
                        timer   <= '0;
                    end
                end
                default: begin
                    state     <= ST_RESET_PLL;
                    timer     <= '0;
                    pll_rst_q <= 1'b1;
                    ch_q      <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst      = pll_rst_q;
    assign bus.ch_rst_n     = ch_q;
    assign bus.ready        = ready_q;
    assign bus.fault        = fault_q;
    assign bus.relock_count = relock_q;

endmodule
